// File: rtl/cac_combine_n.sv
// N-lane compare-and-combine: folds same-ID lanes of one beat into the lowest lane.
// Latency PIPE_DEPTH cycles; one beat per cycle while OutReady is high.
// OutReady low freezes every stage and MergeCount; InReady mirrors OutReady.
module cac_combine_n #(
  parameter int DATA_W     = 32,
  parameter int VID_W      = 32,
  parameter int LANES      = 4,
  parameter int PIPE_DEPTH = 3,
  parameter int MODE       = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES-1:0]        InputValid,
  input  logic [LANES*VID_W-1:0]  InDestVid,
  input  logic [LANES*DATA_W-1:0] InUpdate,
  input  logic                    OutReady,
  output logic                    InReady,
  output logic [LANES-1:0]        OutValid,
  output logic [LANES*VID_W-1:0]  OutDestVid,
  output logic [LANES*DATA_W-1:0] OutUpdate,
  output logic [15:0]             MergeCount
);

  // Three extra bits hold the sum of up to 8 full-scale values without overflow.
  localparam int SUM_W = DATA_W + 3;
  localparam int CNT_W = 4;

  if (LANES < 2 || LANES > 8) begin : g_bad_lanes
    $error("cac_combine_n: LANES must be in 2..8");
  end
  if (PIPE_DEPTH < 2) begin : g_bad_depth
    $error("cac_combine_n: PIPE_DEPTH must be at least 2");
  end
  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("cac_combine_n: MODE must be 0, 1 or 2");
  end

  // A single global enable: the whole pipe advances only when downstream takes the output.
  logic adv;
  assign adv     = OutReady;
  assign InReady = OutReady;

  logic [LANES-1:0]        s1_vld;
  logic [LANES*VID_W-1:0]  s1_vid;
  logic [LANES*DATA_W-1:0] s1_upd;

  // Stage 1: capture the raw beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld <= '0;
      s1_vid <= '0;
      s1_upd <= '0;
    end else if (adv) begin
      s1_vld <= InputValid;
      s1_vid <= InDestVid;
      s1_upd <= InUpdate;
    end
  end

  logic [LANES-1:0]        c_vld;
  logic [LANES*VID_W-1:0]  c_vid;
  logic [LANES*DATA_W-1:0] c_upd;
  logic [CNT_W-1:0]        c_merges;
  logic [CNT_W-1:0]        n_in;
  logic [CNT_W-1:0]        n_out;
  logic [SUM_W-1:0]        acc_sum;
  logic [DATA_W-1:0]       acc_red;
  logic [DATA_W-1:0]       upd_j;
  logic                    first;

  // Combine: a lane survives if no lower valid lane shares its ID; it reduces itself and all
  // higher valid lanes with the same ID. Lower matching lanes cannot exist for a survivor.
  always_comb begin
    c_vld   = '0;
    c_vid   = '0;
    c_upd   = '0;
    n_in    = '0;
    n_out   = '0;
    acc_sum = '0;
    acc_red = '0;
    upd_j   = '0;
    first   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      first = s1_vld[i];
      for (int k = 0; k < i; k++) begin
        if (s1_vld[k] && (s1_vid[k*VID_W +: VID_W] == s1_vid[i*VID_W +: VID_W])) begin
          first = 1'b0;
        end
      end
      acc_sum = '0;
      acc_red = s1_upd[i*DATA_W +: DATA_W];
      for (int j = i; j < LANES; j++) begin
        upd_j = s1_upd[j*DATA_W +: DATA_W];
        if (s1_vld[j] && (s1_vid[j*VID_W +: VID_W] == s1_vid[i*VID_W +: VID_W])) begin
          acc_sum = acc_sum + SUM_W'(upd_j);
          if (MODE == 1 && upd_j < acc_red) acc_red = upd_j;
          if (MODE == 2 && upd_j > acc_red) acc_red = upd_j;
        end
      end
      if (MODE == 0) begin
        acc_red = (acc_sum > SUM_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : acc_sum[DATA_W-1:0];
      end
      if (s1_vld[i]) n_in = n_in + CNT_W'(1);
      if (first) begin
        n_out                      = n_out + CNT_W'(1);
        c_vld[i]                   = 1'b1;
        c_vid[i*VID_W +: VID_W]    = s1_vid[i*VID_W +: VID_W];
        c_upd[i*DATA_W +: DATA_W]  = acc_red;
      end
    end
    c_merges = n_in - n_out;
  end

  logic [LANES-1:0]        p_vld [2:PIPE_DEPTH];
  logic [LANES*VID_W-1:0]  p_vid [2:PIPE_DEPTH];
  logic [LANES*DATA_W-1:0] p_upd [2:PIPE_DEPTH];

  // Stage 2 takes the combined beat; later stages are a plain delay line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 2; s <= PIPE_DEPTH; s++) begin
        p_vld[s] <= '0;
        p_vid[s] <= '0;
        p_upd[s] <= '0;
      end
    end else if (adv) begin
      p_vld[2] <= c_vld;
      p_vid[2] <= c_vid;
      p_upd[2] <= c_upd;
      for (int s = 3; s <= PIPE_DEPTH; s++) begin
        p_vld[s] <= p_vld[s-1];
        p_vid[s] <= p_vid[s-1];
        p_upd[s] <= p_upd[s-1];
      end
    end
  end

  assign OutValid   = p_vld[PIPE_DEPTH];
  assign OutDestVid = p_vid[PIPE_DEPTH];
  assign OutUpdate  = p_upd[PIPE_DEPTH];

  logic [16:0] mc_next;
  assign mc_next = {1'b0, MergeCount} + 17'(c_merges);

  // Merge counter advances together with the stage-2 load and sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MergeCount <= '0;
    end else if (adv) begin
      MergeCount <= mc_next[16] ? 16'hFFFF : mc_next[15:0];
    end
  end

endmodule
